// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the 2:1 Wishbone arbiter.
// Round-robin arbitration is enabled by defining WB_ARB_ROUND_ROBIN_EN.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } arb_state_e;

    localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 255;
    localparam int unsigned TMR_WIDTH              = 10;

endpackage : wb_arb_pkg

// File: rtl/wb_arb_timer.sv
// Slave-response timeout counter: clears while not waiting, counts while waiting,
// and flags terminal count once TERMINAL wait cycles have elapsed.
module wb_arb_timer
    import wb_arb_pkg::*;
#(
    parameter int unsigned TERMINAL = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic tc_o
);

    logic [TMR_WIDTH-1:0] cnt_q;
    logic [TMR_WIDTH-1:0] cnt_d;

    assign tc_o = (cnt_q == TMR_WIDTH'(TERMINAL));

    // Saturates at terminal count so a stuck enable never wraps back to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && !tc_o) begin
            cnt_d = cnt_q + TMR_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : wb_arb_timer

// File: rtl/wb_arbiter_2to1.sv
// Two-master to one-slave pipelined Wishbone arbiter with response timeout.
// Define WB_ARB_ROUND_ROBIN_EN for round-robin ties; otherwise master 0 has priority.
module wb_arbiter_2to1
    import wb_arb_pkg::*;
#(
    parameter int          ADDR_WIDTH     = 32,
    parameter int          DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,

    input  logic                    m0_wb_cyc_i,
    input  logic                    m0_wb_stb_i,
    input  logic                    m0_wb_we_i,
    input  logic [ADDR_WIDTH-1:0]   m0_wb_adr_i,
    input  logic [DATA_WIDTH-1:0]   m0_wb_dat_i,
    input  logic [DATA_WIDTH/8-1:0] m0_wb_sel_i,
    output logic                    m0_wb_stall_o,
    output logic                    m0_wb_ack_o,
    output logic                    m0_wb_err_o,
    output logic [DATA_WIDTH-1:0]   m0_wb_dat_o,

    input  logic                    m1_wb_cyc_i,
    input  logic                    m1_wb_stb_i,
    input  logic                    m1_wb_we_i,
    input  logic [ADDR_WIDTH-1:0]   m1_wb_adr_i,
    input  logic [DATA_WIDTH-1:0]   m1_wb_dat_i,
    input  logic [DATA_WIDTH/8-1:0] m1_wb_sel_i,
    output logic                    m1_wb_stall_o,
    output logic                    m1_wb_ack_o,
    output logic                    m1_wb_err_o,
    output logic [DATA_WIDTH-1:0]   m1_wb_dat_o,

    output logic                    s_wb_cyc_o,
    output logic                    s_wb_stb_o,
    output logic                    s_wb_we_o,
    output logic [ADDR_WIDTH-1:0]   s_wb_adr_o,
    output logic [DATA_WIDTH-1:0]   s_wb_dat_o,
    output logic [DATA_WIDTH/8-1:0] s_wb_sel_o,
    input  logic                    s_wb_ack_i,
    input  logic                    s_wb_err_i,
    input  logic                    s_wb_stall_i,
    input  logic [DATA_WIDTH-1:0]   s_wb_dat_i
);

    arb_state_e                state_q, state_d;
    logic                      grant_q, grant_d;
    logic                      we_q, we_d;
    logic [ADDR_WIDTH-1:0]     adr_q, adr_d;
    logic [DATA_WIDTH-1:0]     dat_q, dat_d;
    logic [DATA_WIDTH/8-1:0]   sel_q, sel_d;
`ifdef WB_ARB_ROUND_ROBIN_EN
    logic                      last_grant_q, last_grant_d;
`endif

    logic req0, req1, any_req, winner;
    logic slave_done, tc, timeout, active, latch;
    logic m0_sel, m1_sel;

    assign req0       = m0_wb_cyc_i && m0_wb_stb_i;
    assign req1       = m1_wb_cyc_i && m1_wb_stb_i;
    assign any_req    = req0 || req1;
    assign slave_done = s_wb_ack_i || s_wb_err_i;

    // winner=1 selects master 1; only meaningful while any_req is set.
`ifdef WB_ARB_ROUND_ROBIN_EN
    assign winner = (req0 && req1) ? !last_grant_q : req1;
`else
    assign winner = !req0;
`endif

    wb_arb_timer #(
        .TERMINAL (TIMEOUT_CYCLES)
    ) u_timer (
        .clk_i    (wb_clk_i),
        .rst_i    (wb_rst_i),
        .clear_i  (state_q != WAIT),
        .enable_i (state_q == WAIT),
        .tc_o     (tc)
    );

    assign timeout = (state_q == WAIT) && tc && !slave_done;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        we_d    = we_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
`ifdef WB_ARB_ROUND_ROBIN_EN
        last_grant_d = last_grant_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_d = winner;
                    we_d    = winner ? m1_wb_we_i  : m0_wb_we_i;
                    adr_d   = winner ? m1_wb_adr_i : m0_wb_adr_i;
                    dat_d   = winner ? m1_wb_dat_i : m0_wb_dat_i;
                    sel_d   = winner ? m1_wb_sel_i : m0_wb_sel_i;
`ifdef WB_ARB_ROUND_ROBIN_EN
                    last_grant_d = winner;
`endif
                    state_d = REQ;
                end
            end
            REQ: begin
                if (slave_done) begin
                    state_d = IDLE;
                end else if (!s_wb_stall_i) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (slave_done || tc) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            grant_q <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
`ifdef WB_ARB_ROUND_ROBIN_EN
            last_grant_q <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
`ifdef WB_ARB_ROUND_ROBIN_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    assign active     = (state_q != IDLE);
    assign s_wb_cyc_o = active;
    assign s_wb_stb_o = (state_q == REQ);
    assign s_wb_we_o  = we_q;
    assign s_wb_adr_o = adr_q;
    assign s_wb_dat_o = dat_q;
    assign s_wb_sel_o = sel_q;

    // Responses are gated by reset so a late slave ack never leaks out.
    assign m0_sel = active && !grant_q && !wb_rst_i && m0_wb_cyc_i;
    assign m1_sel = active &&  grant_q && !wb_rst_i && m1_wb_cyc_i;

    assign m0_wb_ack_o = s_wb_ack_i && m0_sel;
    assign m1_wb_ack_o = s_wb_ack_i && m1_sel;
    assign m0_wb_err_o = (s_wb_err_i || timeout) && m0_sel;
    assign m1_wb_err_o = (s_wb_err_i || timeout) && m1_sel;

    assign m0_wb_dat_o = s_wb_dat_i;
    assign m1_wb_dat_o = s_wb_dat_i;

    assign latch         = (state_q == IDLE) && any_req && !wb_rst_i;
    assign m0_wb_stall_o = !(latch && !winner);
    assign m1_wb_stall_o = !(latch &&  winner);

endmodule : wb_arbiter_2to1
